i2c_bus_monitor: RTL and testbench

Passive byte-level observer placed downstream of the I2C master/slave pair, tapping the shared scl/sda lines. Detects START/STOP, deserialises each 8-bit byte plus its ACK bit and pushes one entry per byte into an internal FIFO for host readout. Never drives the bus; used for debug capture and as a self-check consumer of master/slave traffic.

---
 rtl/i2c_mon_pkg.sv | 14 +
 rtl/i2c_mon_fifo.sv | 46 ++++
 rtl/i2c_bus_monitor.sv | 183 ++++++++++++++++++
 tb/tb_i2c_bus_monitor.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_mon_pkg.sv
// Shared definitions for the I2C bus monitor: capture entry layout and monitor FSM states.
package i2c_mon_pkg;

    localparam int ENTRY_W   = 10;
    localparam int FIRST_BIT = 9;
    localparam int ACK_BIT   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BITS = 2'd1,
        ACK  = 2'd2
    } mon_state_t;

endpackage

// File: rtl/i2c_mon_fifo.sv
// First-word-fall-through synchronous FIFO holding captured I2C byte entries.
module i2c_mon_fifo
    import i2c_mon_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr;
    logic             do_push, do_pop;

    // A pop frees a slot in the same cycle, so a push against a full FIFO still lands.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/i2c_bus_monitor.sv
// Passive I2C observer: START/STOP detection, byte+ACK capture into a FWFT FIFO.
// Optional 3-sample line filter enabled by defining I2C_MON_GLITCH_FILTER_EN.
module i2c_bus_monitor
    import i2c_mon_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               scl,
    input  logic               sda,
    input  logic               rd_en,
    input  logic               clr_ovf,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               empty,
    output logic               full,
    output logic               overflow,
    output logic               bus_busy,
    output logic               start_det,
    output logic               stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_s, sda_s;
    logic                   scl_f, sda_f;
    logic                   scl_d, sda_d;

    // Synchronisers reset to the idle-high bus level so release from reset is edge-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

`ifdef I2C_MON_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;
    logic       scl_hold, sda_hold;

    // Output follows the line only once the current and two previous samples agree.
    assign scl_f = (scl_hist == {2{scl_s}}) ? scl_s : scl_hold;
    assign sda_f = (sda_hist == {2{sda_s}}) ? sda_s : sda_hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_hist <= '1;
            sda_hist <= '1;
            scl_hold <= 1'b1;
            sda_hold <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_s};
            sda_hist <= {sda_hist[0], sda_s};
            scl_hold <= scl_f;
            sda_hold <= sda_f;
        end
    end
`else
    assign scl_f = scl_s;
    assign sda_f = sda_s;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    logic scl_rise, start_cond, stop_cond;

    assign scl_rise   = scl_f & ~scl_d;
    assign start_cond = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_cond  = scl_f & scl_d & ~sda_d & sda_f;

    mon_state_t         state, state_nx;
    logic [2:0]         bit_cnt, bit_cnt_nx;
    logic [7:0]         shift, shift_nx;
    logic               first, first_nx;
    logic               push;
    logic [ENTRY_W-1:0] entry;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            first   <= 1'b0;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            shift   <= shift_nx;
            first   <= first_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shift_nx   = shift;
        first_nx   = first;
        push       = 1'b0;
        entry      = '0;
        entry[FIRST_BIT] = first;
        entry[ACK_BIT]   = sda_f;
        entry[7:0]       = shift;

        if (stop_cond) begin
            state_nx   = IDLE;
            bit_cnt_nx = '0;
            shift_nx   = '0;
            first_nx   = 1'b0;
        end else if (start_cond) begin
            state_nx   = BITS;
            bit_cnt_nx = '0;
            shift_nx   = '0;
            first_nx   = 1'b1;
        end else begin
            case (state)
                BITS: begin
                    if (scl_rise) begin
                        shift_nx   = {shift[6:0], sda_f};
                        bit_cnt_nx = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state_nx = ACK;
                    end
                end
                ACK: begin
                    if (scl_rise) begin
                        push       = 1'b1;
                        first_nx   = 1'b0;
                        bit_cnt_nx = '0;
                        state_nx   = BITS;
                    end
                end
                default: ;
            endcase
        end
    end

    i2c_mon_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (rd_en),
        .wdata (entry),
        .rdata (rd_data),
        .empty (empty),
        .full  (full)
    );

    logic drop;
    assign drop = push & full & ~rd_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            bus_busy  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            start_det <= start_cond;
            stop_det  <= stop_cond;
            if (stop_cond)       bus_busy <= 1'b0;
            else if (start_cond) bus_busy <= 1'b1;
            // A fresh drop outranks a clear issued in the same cycle.
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Bench for i2c_bus_monitor: bit-level I2C driver with a queue-based capture model.
module tb_i2c_bus_monitor;

    localparam int DEPTH = 8;
    localparam int SYNC  = 2;
    localparam int H     = 8;
`ifdef I2C_MON_GLITCH_FILTER_EN
    localparam int LAT = SYNC + 3;
`else
    localparam int LAT = SYNC + 1;
`endif

    logic       clk = 1'b0;
    logic       reset, scl, sda, rd_en, clr_ovf;
    logic [9:0] rd_data;
    logic       empty, full, overflow, bus_busy, start_det, stop_det;

    i2c_bus_monitor #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda       (sda),
        .rd_en     (rd_en),
        .clr_ovf   (clr_ovf),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .bus_busy  (bus_busy),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int n_start = 0, n_stop = 0, exp_start = 0, exp_stop = 0;

    always @(posedge clk) begin
        if (start_det) n_start <= n_start + 1;
        if (stop_det)  n_stop  <= n_stop + 1;
    end

    // Reference model: expected capture queue, first-byte flag, sticky overflow.
    logic [9:0] q[$];
    logic       m_first = 1'b0;
    logic       m_ovf   = 1'b0;
    logic       m_busy  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic waitc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v, input bit with_pop);
        sda = v;
        waitc(H);
        scl = 1'b1;
        if (with_pop) begin
            waitc(LAT - 1);
            rd_en = 1'b1;
            waitc(1);
            rd_en = 1'b0;
            waitc(H - LAT);
        end else begin
            waitc(H);
        end
        scl = 1'b0;
        waitc(H);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(b[i], 1'b0);
    endtask

    task automatic i2c_start();
        sda = 1'b1; waitc(H);
        scl = 1'b1; waitc(H);
        sda = 1'b0; waitc(H);
        scl = 1'b0; waitc(H);
        m_first = 1'b1;
        m_busy  = 1'b1;
        exp_start++;
    endtask

    task automatic i2c_stop();
        sda = 1'b0; waitc(H);
        scl = 1'b1; waitc(H);
        sda = 1'b1; waitc(H);
        m_busy = 1'b0;
        exp_stop++;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack, input bit with_pop);
        if (with_pop) begin
            chk("head_before_pop", rd_data, q[0]);
            void'(q.pop_front());
        end
        send_bits(b, 8);
        send_bit(ack, with_pop);
        if (q.size() < DEPTH) q.push_back({m_first, ack, b});
        else                  m_ovf = 1'b1;
        m_first = 1'b0;
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_empty"}, empty, (q.size() == 0));
        chk({tag, "_full"}, full, (q.size() == DEPTH));
        chk({tag, "_ovf"}, overflow, m_ovf);
        chk({tag, "_busy"}, bus_busy, m_busy);
        chk({tag, "_nstart"}, n_start, exp_start);
        chk({tag, "_nstop"}, n_stop, exp_stop);
    endtask

    task automatic drain(input string tag);
        while (q.size() > 0) begin
            chk({tag, "_notempty"}, empty, 1'b0);
            chk({tag, "_rd_data"}, rd_data, q[0]);
            rd_en = 1'b1;
            waitc(1);
            rd_en = 1'b0;
            void'(q.pop_front());
        end
        chk({tag, "_empty"}, empty, 1'b1);
    endtask

    logic [7:0] rb;
    logic       ra;
    int         nb;

    initial begin
        reset = 1'b1; scl = 1'b1; sda = 1'b1; rd_en = 1'b0; clr_ovf = 1'b0;
        waitc(3);
        chk("rst_rd_data", rd_data, 10'd0);
        chk("rst_start_det", start_det, 1'b0);
        chk("rst_stop_det", stop_det, 1'b0);
        check_status("rst");

        reset = 1'b0;
        waitc(100);
        check_status("idle");

        // Address byte with ACK, then two read bytes (ACK, NACK) and STOP.
        i2c_start();
        send_byte(8'b10010101, 1'b0, 1'b0);
        chk("addr_entry", rd_data, 10'b1_0_10010101);
        check_status("addr");
        send_byte(8'b10100110, 1'b0, 1'b0);
        send_byte(8'b11100100, 1'b1, 1'b0);
        i2c_stop();
        waitc(4);
        check_status("rd_stop");
        drain("rd");

        // Repeated START in the middle of a byte discards the partial bits.
        i2c_start();
        send_bits(8'hF0, 4);
        i2c_start();
        send_byte(8'b10010100, 1'b1, 1'b0);
        i2c_stop();
        waitc(4);
        check_status("rstart");
        drain("rstart");

        // DEPTH+1 bytes overflow; then clear; then a push coinciding with a pop.
        i2c_start();
        for (int i = 0; i < DEPTH + 1; i++) begin
            rb = 8'($urandom);
            ra = 1'($urandom);
            send_byte(rb, ra, 1'b0);
        end
        check_status("ovf");
        clr_ovf = 1'b1;
        waitc(1);
        clr_ovf = 1'b0;
        m_ovf = 1'b0;
        chk("ovf_cleared", overflow, 1'b0);
        rb = 8'($urandom);
        send_byte(rb, 1'b0, 1'b1);
        i2c_stop();
        waitc(4);
        check_status("simul");
        drain("simul");

        // Randomized transactions with optional repeated STARTs.
        for (int t = 0; t < 4; t++) begin
            i2c_start();
            nb = int'($urandom_range(1, 3));
            for (int b = 0; b < nb; b++) begin
                rb = 8'($urandom);
                ra = 1'($urandom);
                send_byte(rb, ra, 1'b0);
                if ($urandom_range(0, 2) == 0) i2c_start();
            end
            i2c_stop();
            waitc(4);
            check_status("rand");
            drain("rand");
        end

        // Reset mid-transfer; bits afterwards without a START are ignored.
        i2c_start();
        send_bits(8'hA5, 5);
        reset = 1'b1;
        waitc(2);
        q.delete();
        m_ovf = 1'b0;
        m_busy = 1'b0;
        check_status("midrst");
        scl = 1'b1; sda = 1'b1;
        waitc(4);
        reset = 1'b0;
        waitc(4);
        scl = 1'b0;
        waitc(H);
        send_bits(8'h5A, 8);
        send_bit(1'b0, 1'b0);
        i2c_stop();
        waitc(4);
        check_status("postrst");

        // One-clock sda glitch while scl is high.
        @(posedge clk); #1 sda = 1'b0;
        @(posedge clk); #1 sda = 1'b1;
        waitc(12);
`ifndef I2C_MON_GLITCH_FILTER_EN
        exp_start++;
        exp_stop++;
`endif
        check_status("glitch");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
